// File: rtl/mux4_rr_arbiter_if.sv
// Bundle between the four requesting lanes, the round-robin arbiter and the
// downstream consumer of the shared 4:1 mux output.
interface mux4_rr_arbiter_if #(
    parameter int DATA_W = 1
);
    logic [3:0]          req;
    logic [4*DATA_W-1:0] d;
    logic [3:0]          grant;
    logic [1:0]          sel;
    logic [DATA_W-1:0]   out_data;
    logic                out_valid;
    logic                busy;

    modport master (
        output req, d,
        input  grant, sel, out_data, out_valid, busy
    );

    modport slave (
        input  req, d,
        output grant, sel, out_data, out_valid, busy
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux: picks a lane, bounds its tenure to
// HOLD_MAX cycles while others wait, drives the select and registers the data.
module mux4_rr_arbiter #(
    parameter int DATA_W   = 1,
    parameter int HOLD_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mux4_rr_arbiter_if.slave   bus
);
    localparam int HC_W = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [HC_W-1:0] HOLD_LIM = HC_W'(HOLD_MAX);
    localparam logic [HC_W-1:0] HC_ONE   = HC_W'(1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]        state, state_nx;
    logic [3:0]        grant, grant_nx;
    logic [1:0]        sel, sel_nx;
    logic [1:0]        ptr, ptr_nx;
    logic [HC_W-1:0]   hold_cnt, hold_nx;
    logic [DATA_W-1:0] out_data;
    logic              vld_p1;
    logic [DATA_W-1:0] lanes [4];
    logic [1:0]        winner;
    logic              expired;

    // First requesting lane after p in circular order; p itself is checked last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic       found;
        rr_pick = p;
        found   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = p + 2'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign lanes[g] = bus.d[g*DATA_W +: DATA_W];
    end

    assign winner  = rr_pick(bus.req, ptr);
    assign expired = (HOLD_MAX != 0) && (hold_cnt == HOLD_LIM) && ((bus.req & ~grant) != 4'b0);

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        sel_nx   = sel;
        ptr_nx   = ptr;
        hold_nx  = hold_cnt;
        if (state == IDLE) begin
            if (bus.req != 4'b0) begin
                state_nx = GRANT;
                grant_nx = 4'b0001 << winner;
                sel_nx   = winner;
                ptr_nx   = winner;
                hold_nx  = HC_ONE;
            end
        end else if (bus.req[sel] && !expired) begin
            // Lone holder past its limit starts a fresh tenure instead of saturating.
            if (HOLD_MAX != 0) begin
                hold_nx = (hold_cnt == HOLD_LIM) ? HC_ONE : hold_cnt + HC_ONE;
            end
        end else if (bus.req != 4'b0) begin
            grant_nx = 4'b0001 << winner;
            sel_nx   = winner;
            ptr_nx   = winner;
            hold_nx  = HC_ONE;
        end else begin
            state_nx = IDLE;
            grant_nx = 4'b0;
        end
    end

    // Arbitration and data registers share one edge; data follows the current grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= 4'b0;
            sel      <= 2'd0;
            ptr      <= 2'd3;
            hold_cnt <= '0;
            out_data <= '0;
            vld_p1   <= 1'b0;
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            sel      <= sel_nx;
            ptr      <= ptr_nx;
            hold_cnt <= hold_nx;
            vld_p1   <= |(grant & bus.req);
            if (|(grant & bus.req)) begin
                out_data <= lanes[sel];
            end
        end
    end

    assign bus.grant     = grant;
    assign bus.sel       = sel;
    assign bus.out_data  = out_data;
    assign bus.out_valid = vld_p1;
    assign bus.busy      = (state == GRANT);
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: a vector table for single-edge behaviour
// plus hand sequences for rotation, lone holder and asynchronous reset.
module tb_mux4_rr_arbiter;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter_if #(.DATA_W(DW)) bus ();

    mux4_rr_arbiter #(.DATA_W(DW), .HOLD_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [3:0]  req;
        logic [15:0] d;
        logic [3:0]  grant;
        logic [1:0]  sel;
        logic [3:0]  od;
        logic        ov;
        logic        busy;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(input logic [3:0] r, input logic [15:0] dd, input logic [3:0] g,
                                input logic [1:0] s, input logic [3:0] o, input logic v, input logic b);
        vec_t t;
        t.req = r; t.d = dd; t.grant = g; t.sel = s; t.od = o; t.ov = v; t.busy = b;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.req = 4'b0;
        bus.d   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req = 4'hF;
        bus.d   = 16'hFFFF;

        // reset held low with all lanes requesting
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_sel", 32'(bus.sel), 32'h0);
        check("rst_ov", 32'(bus.out_valid), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_od", 32'(bus.out_data), 32'h0);

        tbl[0]  = mk(4'b0000, 16'h1234, 4'b0000, 2'd0, 4'h0, 1'b0, 1'b0);
        tbl[1]  = mk(4'b0100, 16'h0100, 4'b0100, 2'd2, 4'h0, 1'b0, 1'b1);
        tbl[2]  = mk(4'b0100, 16'h0100, 4'b0100, 2'd2, 4'h1, 1'b1, 1'b1);
        tbl[3]  = mk(4'b0000, 16'h0100, 4'b0000, 2'd2, 4'h1, 1'b0, 1'b0);
        tbl[4]  = mk(4'b0000, 16'h0F00, 4'b0000, 2'd2, 4'h1, 1'b0, 1'b0);
        tbl[5]  = mk(4'b1011, 16'h9876, 4'b1000, 2'd3, 4'h1, 1'b0, 1'b1);
        tbl[6]  = mk(4'b0010, 16'h9876, 4'b0010, 2'd1, 4'h1, 1'b0, 1'b1);
        tbl[7]  = mk(4'b0010, 16'h9876, 4'b0010, 2'd1, 4'h7, 1'b1, 1'b1);
        tbl[8]  = mk(4'b1010, 16'h9876, 4'b0010, 2'd1, 4'h7, 1'b1, 1'b1);
        tbl[9]  = mk(4'b1000, 16'h9876, 4'b1000, 2'd3, 4'h7, 1'b0, 1'b1);
        tbl[10] = mk(4'b0011, 16'h9876, 4'b0001, 2'd0, 4'h7, 1'b0, 1'b1);
        tbl[11] = mk(4'b0000, 16'h9876, 4'b0000, 2'd0, 4'h7, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.req = tbl[i].req;
            bus.d   = tbl[i].d;
            step();
            check($sformatf("v%0d_grant", i), 32'(bus.grant), 32'(tbl[i].grant));
            check($sformatf("v%0d_sel", i), 32'(bus.sel), 32'(tbl[i].sel));
            check($sformatf("v%0d_od", i), 32'(bus.out_data), 32'(tbl[i].od));
            check($sformatf("v%0d_ov", i), 32'(bus.out_valid), 32'(tbl[i].ov));
            check($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
        end

        // rotation: four cycles per lane, back-to-back tenures
        do_reset();
        bus.req = 4'hF;
        bus.d   = 16'h4321;
        for (int c = 0; c < 20; c++) begin
            step();
            check($sformatf("rot%0d_grant", c), 32'(bus.grant), 32'(4'b0001 << ((c / 4) % 4)));
            check($sformatf("rot%0d_onehot", c), 32'($onehot(bus.grant)), 32'h1);
            if (c >= 1) begin
                check($sformatf("rot%0d_od", c), 32'(bus.out_data), 32'((((c - 1) / 4) % 4) + 1));
                check($sformatf("rot%0d_ov", c), 32'(bus.out_valid), 32'h1);
            end
        end

        // lone holder keeps the grant; its count restarts at each expiry
        do_reset();
        bus.req = 4'b0001;
        bus.d   = 16'h000A;
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("lone%0d_grant", c), 32'(bus.grant), 32'h1);
        end
        bus.req = 4'b0011;
        step();
        check("lone_cnt3_grant", 32'(bus.grant), 32'h1);
        step();
        check("lone_cnt4_grant", 32'(bus.grant), 32'h1);
        step();
        check("lone_expire_grant", 32'(bus.grant), 32'h2);
        check("lone_expire_od", 32'(bus.out_data), 32'hA);

        // asynchronous reset in the middle of a lane-2 tenure
        do_reset();
        bus.req = 4'b0100;
        bus.d   = 16'h0500;
        step();
        step();
        check("ar_pre_grant", 32'(bus.grant), 32'h4);
        check("ar_pre_ov", 32'(bus.out_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_grant", 32'(bus.grant), 32'h0);
        check("ar_sel", 32'(bus.sel), 32'h0);
        check("ar_ov", 32'(bus.out_valid), 32'h0);
        check("ar_busy", 32'(bus.busy), 32'h0);
        check("ar_od", 32'(bus.out_data), 32'h0);
        @(negedge clk);
        bus.req = 4'b0110;
        rst_n   = 1'b1;
        step();
        check("ar_rel_grant", 32'(bus.grant), 32'h2);
        check("ar_rel_sel", 32'(bus.sel), 32'h1);
        check("ar_rel_ov", 32'(bus.out_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
